// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer
//   Command-side driver for a stack-based ALU. Consumes a reverse-Polish token
//   stream over a valid/ready handshake, turns every token into the matching
//   ALU command sequence, tracks the ALU stack depth and returns one result
//   (with overflow/error flags) per expression.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   tok_valid / tok_ready    token handshake
//   tok_is_op, tok_op        token kind (operand/operator) and operator (0 add, 1 mul)
//   tok_data, tok_last       operand value and end-of-expression marker
//   alu_opcode, alu_in       ALU command (-4 add, -3 mul, -2 push, -1 pop, 0 nop) and push data
//   alu_out, alu_overflow    ALU result / pop data and overflow flag
//   res_valid                one-cycle result pulse carrying res_data/res_overflow/res_error
//   depth                    tracked ALU stack depth
//
// LAT must be at least 1.
module stack_alu_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned LAT   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic         tok_op,
  input  logic [N-1:0] tok_data,
  input  logic         tok_last,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_in,
  input  logic [N-1:0] alu_out,
  input  logic         alu_overflow,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error,
  output logic [9:0]   depth
);

  // Two's-complement 3-bit opcodes.
  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpPush = 3'b110;
  localparam logic [2:0] OpPop  = 3'b111;

  localparam int unsigned     CntW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(LAT - 1);
  localparam logic [9:0]      DepthMax = 10'(DEPTH);

  typedef enum logic [3:0] {
    StIdle, StPush, StOp, StWait, StCap, StPop1, StGap1, StPop2, StGap2,
    StPushr, StFpop, StFwait, StErr, StDiscard, StFlPop, StFlGap
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      depth_q, depth_d;
  logic            sticky_q, sticky_d;
  logic [N-1:0]    tmp_q, tmp_d;
  logic            last_q, last_d;
  logic            op_q, op_d;
  logic [CntW-1:0] wcnt_q, wcnt_d;
  logic            fin_done;
  logic            flush_check;
  logic            accept;

  logic [2:0]   opcode_d;
  logic [N-1:0] alu_in_d;
  logic         tok_ready_d;
  logic         res_valid_d;
  logic [N-1:0] res_data_d;
  logic         res_overflow_d;
  logic         res_error_d;

  // tok_ready is registered and high exactly while in StIdle/StDiscard.
  assign accept = tok_valid & tok_ready;
  assign depth  = depth_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      depth_q  <= '0;
      sticky_q <= 1'b0;
      tmp_q    <= '0;
      last_q   <= 1'b0;
      op_q     <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      sticky_q <= sticky_d;
      tmp_q    <= tmp_d;
      last_q   <= last_d;
      op_q     <= op_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    sticky_d    = sticky_q;
    tmp_d       = tmp_q;
    last_d      = last_q;
    op_d        = op_q;
    wcnt_d      = wcnt_q;
    fin_done    = 1'b0;
    flush_check = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_d = tok_last;
          op_d   = tok_op;
          if (tok_is_op) begin
            state_d = (depth_q < 10'd2) ? StErr : StOp;
          end else if (depth_q == DepthMax) begin
            state_d = StErr;
          end else begin
            state_d = StPush;
            depth_d = depth_q + 10'd1;
          end
        end
      end
      // depth_q already includes this push, so the final check sees the true depth.
      StPush, StPushr: begin
        if (!last_q) begin
          state_d = StIdle;
        end else begin
          state_d = (depth_q == 10'd1) ? StFpop : StErr;
        end
      end
      StOp: begin
        state_d = StWait;
        wcnt_d  = '0;
      end
      StWait: begin
        if (wcnt_q == WaitLast) begin
          state_d = StCap;
        end else begin
          wcnt_d = wcnt_q + CntW'(1);
        end
      end
      StCap: begin
        tmp_d    = alu_out;
        sticky_d = sticky_q | alu_overflow;
        state_d  = StPop1;
      end
      StPop1: state_d = StGap1;
      StGap1: state_d = StPop2;
      StPop2: state_d = StGap2;
      StGap2: begin
        state_d = StPushr;
        depth_d = depth_q - 10'd1;  // two pops plus one push
      end
      StFpop: begin
        state_d = StFwait;
        wcnt_d  = '0;
      end
      StFwait: begin
        if (wcnt_q == WaitLast) begin
          state_d  = StIdle;
          depth_d  = '0;
          sticky_d = 1'b0;
          fin_done = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CntW'(1);
        end
      end
      StErr: begin
        if (last_q) begin
          flush_check = 1'b1;
        end else begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (accept && tok_last) begin
          flush_check = 1'b1;
        end
      end
      StFlPop: begin
        state_d = StFlGap;
        depth_d = depth_q - 10'd1;
      end
      StFlGap: flush_check = 1'b1;
      default: state_d = StIdle;
    endcase

    // Drain whatever the aborted expression left on the ALU stack.
    if (flush_check) begin
      if (depth_q != 10'd0) begin
        state_d = StFlPop;
      end else begin
        state_d  = StIdle;
        sticky_d = 1'b0;
      end
    end
  end

  // Output decode from the next state, so every output comes straight from a flop.
  always_comb begin
    opcode_d       = OpNop;
    alu_in_d       = alu_in;
    tok_ready_d    = 1'b0;
    res_valid_d    = 1'b0;
    res_data_d     = '0;
    res_overflow_d = 1'b0;
    res_error_d    = 1'b0;
    case (state_d)
      StPush: begin
        opcode_d = OpPush;
        alu_in_d = tok_data;
      end
      StPushr: begin
        opcode_d = OpPush;
        alu_in_d = tmp_q;
      end
      StOp:                              opcode_d = op_d ? OpMul : OpAdd;
      StPop1, StPop2, StFpop, StFlPop:   opcode_d = OpPop;
      StIdle, StDiscard:                 tok_ready_d = 1'b1;
      StErr: begin
        res_valid_d = 1'b1;
        res_error_d = 1'b1;
      end
      default: ;
    endcase
    if (fin_done) begin
      res_valid_d    = 1'b1;
      res_data_d     = alu_out;
      res_overflow_d = sticky_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode   <= OpNop;
      alu_in       <= '0;
      tok_ready    <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_error    <= 1'b0;
    end else begin
      alu_opcode   <= opcode_d;
      alu_in       <= alu_in_d;
      tok_ready    <= tok_ready_d;
      res_valid    <= res_valid_d;
      res_data     <= res_data_d;
      res_overflow <= res_overflow_d;
      res_error    <= res_error_d;
    end
  end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Testbench for stack_alu_sequencer: drives RPN token streams (directed and
// random) into the sequencer, emulates the stack ALU behind it and compares
// every expression's outcome with a queue-based RPN evaluator.
module tb_stack_alu_sequencer;
  localparam int N   = 8;
  localparam int DEPTH = 512;
  localparam int LAT = 2;
  localparam int unsigned MaxVal = (1 << N) - 1;

  typedef struct packed {
    logic         is_op;
    logic         op;
    logic [N-1:0] data;
  } tok_t;

  typedef struct {
    bit err;
    int data;
    bit ovf;
    int pushes;
    int pops;
    int ariths;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic         tok_op = 1'b0;
  logic [N-1:0] tok_data = '0;
  logic         tok_last = 1'b0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_in;
  logic [N-1:0] alu_out;
  logic         alu_overflow;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic         res_error;
  logic [9:0]   depth;

  int checks = 0;
  int errors = 0;

  int           mon_push = 0, mon_pop = 0, mon_arith = 0, mon_res = 0;
  logic [N-1:0] last_data = '0;
  logic         last_ovf = 1'b0, last_err = 1'b0;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_op    (tok_is_op),
    .tok_op       (tok_op),
    .tok_data     (tok_data),
    .tok_last     (tok_last),
    .alu_opcode   (alu_opcode),
    .alu_in       (alu_in),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .res_error    (res_error),
    .depth        (depth)
  );

  // Stack ALU: arithmetic reads the top two entries without popping; results
  // and pop data appear one cycle after the command and then hold.
  logic [N-1:0] alu_mem [DEPTH];
  int           alu_sp;
  always @(posedge clk or posedge rst) begin
    int unsigned ua, ub, ur;
    if (rst) begin
      alu_sp       <= 0;
      alu_out      <= '0;
      alu_overflow <= 1'b0;
    end else if (alu_opcode != 3'b000) begin
      ua = (alu_sp > 0) ? 32'(alu_mem[alu_sp-1]) : 0;
      ub = (alu_sp > 1) ? 32'(alu_mem[alu_sp-2]) : 0;
      ur = (alu_opcode == 3'b100) ? ua + ub : ua * ub;
      case (alu_opcode)
        3'b110: if (alu_sp < DEPTH) begin
          alu_mem[alu_sp] <= alu_in;
          alu_sp          <= alu_sp + 1;
        end
        3'b111: begin
          alu_out <= N'(ua);
          if (alu_sp > 0) alu_sp <= alu_sp - 1;
        end
        3'b100, 3'b101: begin
          alu_out      <= N'(ur);
          alu_overflow <= (ur > MaxVal);
        end
        default: ;
      endcase
    end
  end

  // Cumulative command and result monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      case (alu_opcode)
        3'b110:         mon_push  <= mon_push + 1;
        3'b111:         mon_pop   <= mon_pop + 1;
        3'b100, 3'b101: mon_arith <= mon_arith + 1;
        default: ;
      endcase
      if (res_valid) begin
        mon_res   <= mon_res + 1;
        last_data <= res_data;
        last_ovf  <= res_overflow;
        last_err  <= res_error;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic tok_t opd(input int v);
    tok_t t;
    t.is_op = 1'b0;
    t.op    = 1'b0;
    t.data  = N'(v);
    return t;
  endfunction

  function automatic tok_t opr(input bit mul);
    tok_t t;
    t.is_op = 1'b1;
    t.op    = mul;
    t.data  = N'($urandom);
    return t;
  endfunction

  // Plain RPN evaluation over a queue; also counts the ALU commands it implies.
  function automatic exp_t ref_model(input tok_t q[$]);
    exp_t        e;
    int unsigned st[$];
    int unsigned a, b, r;
    e = '{default: 0};
    foreach (q[i]) begin
      if (q[i].is_op) begin
        if (st.size() < 2) begin
          e.err = 1;
          e.pops += st.size();
          return e;
        end
        a = st.pop_back();
        b = st.pop_back();
        r = q[i].op ? a * b : a + b;
        if (r > MaxVal) e.ovf = 1;
        st.push_back(r % (MaxVal + 1));
        e.ariths++;
        e.pushes++;
        e.pops += 2;
      end else begin
        if (st.size() == DEPTH) begin
          e.err = 1;
          e.pops += st.size();
          return e;
        end
        st.push_back(32'(q[i].data));
        e.pushes++;
      end
    end
    if (st.size() != 1) begin
      e.err = 1;
      e.pops += st.size();
    end else begin
      e.data = int'(st[0]);
      e.pops++;
    end
    return e;
  endfunction

  task automatic send_tok(input tok_t t, input bit last);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = t.is_op;
    tok_op    = t.op;
    tok_data  = t.data;
    tok_last  = last;
    n = 0;
    while (tok_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("tok_accept_timeout", 1, 0);
    @(negedge clk);
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    tok_data  = N'($urandom);
  endtask

  task automatic run_expr(input tok_t q[$], input string tag);
    exp_t e;
    int   p0, o0, a0, r0, n;
    e  = ref_model(q);
    p0 = mon_push;
    o0 = mon_pop;
    a0 = mon_arith;
    r0 = mon_res;
    foreach (q[i]) send_tok(q[i], i == q.size() - 1);
    n = 0;
    while (!(mon_res != r0 && tok_ready === 1'b1 && depth === 10'd0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check({tag, "_done_timeout"}, 1, 0);
    repeat (4) @(negedge clk);
    check({tag, "_res_count"}, mon_res - r0, 1);
    check({tag, "_res_error"}, 32'(last_err), 32'(e.err));
    check({tag, "_res_data"}, 32'(last_data), e.err ? 0 : e.data);
    if (!e.err) check({tag, "_res_ovf"}, 32'(last_ovf), 32'(e.ovf));
    check({tag, "_depth"}, 32'(depth), 0);
    check({tag, "_pushes"}, mon_push - p0, e.pushes);
    check({tag, "_pops"}, mon_pop - o0, e.pops);
    check({tag, "_ariths"}, mon_arith - a0, e.ariths);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tok_t q[$];
    int   r0, s, ops_left, opd_left, len;

    repeat (3) @(negedge clk);
    check("reset_opcode", 32'(alu_opcode), 0);
    check("reset_ready", 32'(tok_ready), 0);
    check("reset_res_valid", 32'(res_valid), 0);
    check("reset_res_error", 32'(res_error), 0);
    check("reset_res_data", 32'(res_data), 0);
    check("reset_depth", 32'(depth), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    q.delete(); q.push_back(opd(3)); q.push_back(opd(4)); q.push_back(opr(0));
    run_expr(q, "add_3_4");
    check("add_3_4_value", 32'(last_data), 7);

    q.delete(); q.push_back(opd(20)); q.push_back(opd(13)); q.push_back(opr(1));
    run_expr(q, "mul_20_13");
    check("mul_20_13_value", 32'(last_data), 4);
    check("mul_20_13_ovf", 32'(last_ovf), 1);

    q.delete(); q.push_back(opd(8'h5A));
    run_expr(q, "single");
    check("single_value", 32'(last_data), 32'h5A);

    q.delete(); q.push_back(opr(0)); q.push_back(opd(1));
    run_expr(q, "op_first");

    q.delete(); q.push_back(opd(1)); q.push_back(opd(2));
    run_expr(q, "two_left");

    // Reset while the multiply is waiting on the ALU.
    r0 = mon_res;
    send_tok(opd(20), 1'b0);
    send_tok(opd(13), 1'b0);
    send_tok(opr(1), 1'b1);
    check("rst_pre_mul_opcode", 32'(alu_opcode), 32'(3'b101));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_opcode", 32'(alu_opcode), 0);
    check("rst_mid_res_valid", 32'(res_valid), 0);
    check("rst_mid_depth", 32'(depth), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_result", mon_res - r0, 0);
    q.delete(); q.push_back(opd(2)); q.push_back(opd(5)); q.push_back(opr(0));
    run_expr(q, "after_rst");
    check("after_rst_value", 32'(last_data), 7);

    // Fill to exactly DEPTH entries, then reduce: the last push is legal.
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(opd($urandom_range(0, MaxVal)));
    for (int i = 0; i < DEPTH - 1; i++) q.push_back(opr(0));
    run_expr(q, "full_stack");

    // One push past capacity is an error and flushes the full stack.
    q.delete();
    for (int i = 0; i <= DEPTH; i++) q.push_back(opd($urandom_range(0, MaxVal)));
    run_expr(q, "overflow_push");

    for (int k = 0; k < 40; k++) begin
      q.delete();
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 1) == 1) q.push_back(opr($urandom_range(0, 1)));
          else q.push_back(opd($urandom_range(0, MaxVal)));
        end
      end else begin
        ops_left = $urandom_range(0, 5);
        opd_left = ops_left + 1;
        s = 0;
        while (ops_left > 0 || opd_left > 0) begin
          if (s >= 2 && ops_left > 0 && (opd_left == 0 || $urandom_range(0, 1) == 1)) begin
            q.push_back(opr($urandom_range(0, 1)));
            ops_left--;
            s--;
          end else begin
            q.push_back(opd($urandom_range(0, MaxVal)));
            opd_left--;
            s++;
          end
        end
      end
      run_expr(q, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
